// File: rtl/calc_seq_if.sv
// Key-event handshake and display/result bus between the PS/2 key decoder,
// the calculator sequencer and the display driver.
interface calc_seq_if #(
    parameter int W = 32
);
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_ready;
    logic [W-1:0] disp_val;
    logic [W-1:0] result;
    logic         result_valid;
    logic         err;
    logic [2:0]   state_o;

    modport master (
        output key_valid, key_code,
        input  key_ready, disp_val, result, result_valid, err, state_o
    );

    modport slave (
        input  key_valid, key_code,
        output key_ready, disp_val, result, result_valid, err, state_o
    );
endinterface

// File: rtl/calc_seq.sv
// Calculator sequencer: two-operand decimal entry, + - * in one cycle and an
// optional restoring divider built only when CALC_DIV_EN is defined.
module calc_seq #(
    parameter int DIGITS = 4,
    parameter int W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    calc_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPSEL = 3'd1,
        S_ENTB  = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
`ifdef CALC_DIV_EN
    localparam logic [1:0] OP_DIV = 2'd3;
`endif
    localparam int         CW       = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);

    state_t        state, state_n;
    logic [W-1:0]  a, a_n, b, b_n;
    logic [W-1:0]  result, result_n, alu;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    op, op_n;
    logic          result_valid, rv_n;
    logic          key_ready, take;
    logic          is_dig, is_op, is_ent, is_clr;
    logic [W-1:0]  dig;
    logic [W-1:0]  a_acc, b_acc;
    logic          div_start, div_step, go_err;

    assign key_ready = (state != S_EXEC);
    assign take      = bus.key_valid && key_ready;

    assign is_dig = (bus.key_code < 5'd10);
`ifdef CALC_DIV_EN
    assign is_op  = (bus.key_code[4:2] == 3'b100);
`else
    assign is_op  = (bus.key_code >= 5'h10) && (bus.key_code <= 5'h12);
`endif
    assign is_ent = (bus.key_code == 5'h14);
    assign is_clr = (bus.key_code == 5'h15);
    assign dig    = W'(bus.key_code[3:0]);
    assign a_acc  = a * W'(10) + dig;
    assign b_acc  = b * W'(10) + dig;

    always_comb begin
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_MUL:  alu = a * b;
            default: alu = '0;
        endcase
    end

`ifdef CALC_DIV_EN
    localparam int DCW = (W > 1) ? $clog2(W) : 1;

    logic           div_run, div_last, div_zero, neg, err_q;
    logic [DCW-1:0] div_cnt;
    logic [W-1:0]   rem, rem_nx, quo, quo_nx, dvs, div_res;
    logic [W:0]     shifted, trial;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[W]) begin
            rem_nx = trial[W-1:0];
            quo_nx = {quo[W-2:0], 1'b1};
        end else begin
            rem_nx = shifted[W-1:0];
            quo_nx = {quo[W-2:0], 1'b0};
        end
    end

    assign div_last = (div_cnt == DCW'(W - 1));
    assign div_res  = neg ? -quo_nx : quo_nx;
    assign div_zero = (b == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_run <= 1'b0;
            div_cnt <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (div_start) begin
                div_run <= 1'b1;
                div_cnt <= '0;
                rem     <= '0;
                quo     <= mag(a);
                dvs     <= mag(b);
                neg     <= a[W-1] ^ b[W-1];
            end else if (div_step) begin
                rem     <= rem_nx;
                quo     <= quo_nx;
                div_cnt <= div_cnt + 1'b1;
                if (div_last) div_run <= 1'b0;
            end
            if (take && is_clr) err_q <= 1'b0;
            else if (go_err)    err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        a_n       = a;
        b_n       = b;
        cnt_n     = cnt;
        op_n      = op;
        result_n  = result;
        rv_n      = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        go_err    = 1'b0;
        case (state)
            S_IDLE: if (take) begin
                if (is_dig) begin
                    if (cnt < DIG_MAX) begin
                        a_n   = a_acc;
                        cnt_n = cnt + 1'b1;
                    end
                end else if (is_op && cnt != '0) begin
                    op_n    = bus.key_code[1:0];
                    b_n     = '0;
                    cnt_n   = '0;
                    state_n = S_OPSEL;
                end
            end
            S_OPSEL: if (take) begin
                if (is_dig) begin
                    b_n     = dig;
                    cnt_n   = CW'(1);
                    state_n = S_ENTB;
                end else if (is_op) begin
                    op_n = bus.key_code[1:0];
                end
            end
            S_ENTB: if (take) begin
                if (is_dig) begin
                    if (cnt < DIG_MAX) begin
                        b_n   = b_acc;
                        cnt_n = cnt + 1'b1;
                    end
                end else if (is_ent) begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef CALC_DIV_EN
                if (op == OP_DIV) begin
                    if (!div_run) begin
                        // Zero divisor is caught in the setup cycle, before any iteration.
                        if (div_zero) begin
                            go_err  = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            div_start = 1'b1;
                        end
                    end else begin
                        div_step = 1'b1;
                        if (div_last) begin
                            result_n = div_res;
                            rv_n     = 1'b1;
                            state_n  = S_DONE;
                        end
                    end
                end else
`endif
                begin
                    result_n = alu;
                    rv_n     = 1'b1;
                    state_n  = S_DONE;
                end
            end
            S_DONE: if (take) begin
                if (is_dig) begin
                    a_n     = dig;
                    cnt_n   = CW'(1);
                    state_n = S_IDLE;
                end else if (is_op) begin
                    // Chain: the last result becomes the left operand.
                    a_n     = result;
                    b_n     = '0;
                    cnt_n   = '0;
                    op_n    = bus.key_code[1:0];
                    state_n = S_OPSEL;
                end
            end
            default: ;
        endcase
        if (take && is_clr) begin
            state_n  = S_IDLE;
            a_n      = '0;
            b_n      = '0;
            cnt_n    = '0;
            result_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            a            <= '0;
            b            <= '0;
            cnt          <= '0;
            op           <= OP_ADD;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            a            <= a_n;
            b            <= b_n;
            cnt          <= cnt_n;
            op           <= op_n;
            result       <= result_n;
            result_valid <= rv_n;
        end
    end

    always_comb begin
        case (state)
            S_IDLE, S_OPSEL: bus.disp_val = a;
            S_ENTB, S_EXEC:  bus.disp_val = b;
            S_DONE:          bus.disp_val = result;
            default:         bus.disp_val = '0;
        endcase
    end

    assign bus.key_ready    = key_ready;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq: stimulus pushes expected results, a monitor
// pops them on each result_valid pulse. Divider tests need CALC_DIV_EN.
module tb_calc_seq;
    localparam int W = 32;
    localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_MUL = 5'h12,
                           K_DIV = 5'h13, K_ENT = 5'h14, K_CLR = 5'h15;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    calc_seq_if #(.W(W)) bus();
    calc_seq #(.DIGITS(4), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic key(input logic [4:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string nm);
        int n = 0;
        while (bus.state_o !== s && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(bus.state_o), 32'(s));
    endtask

    task automatic run(input logic [31:0] exp, input int cyc);
        exp_t e;
        e.val = exp;
        e.cyc = cyc;
        sb_q.push_back(e);
        key(K_ENT);
        wait_state(3'd4, "done_state");
        @(negedge clk);
    endtask

    // Monitor: counts key_ready-low cycles per operation and checks each result.
    initial begin
        int   exec_cnt;
        exp_t e;
        exec_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst || bus.state_o == 3'd5) exec_cnt = 0;
            else if (!bus.key_ready) exec_cnt++;
            if (bus.result_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rv_unexpected: got result %0h with nothing expected", bus.result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", bus.result, e.val);
                    check("exec_cycles", 32'(exec_cnt), 32'(e.cyc));
                end
                exec_cnt = 0;
            end
        end
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 5'h0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_ready", 32'(bus.key_ready), 32'd1);
        check("rst_disp", bus.disp_val, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rv", 32'(bus.result_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        key(5'd1); check("dig1_disp", bus.disp_val, 32'd1);
        key(5'd2); check("dig12_disp", bus.disp_val, 32'd12);
        key(K_ADD); check("opsel_state", 32'(bus.state_o), 32'd1);
        key(5'd3); key(5'd4); check("entb_disp", bus.disp_val, 32'd34);
        run(32'd46, 1);
        check("add_disp", bus.disp_val, 32'd46);

        key(5'd5); key(K_SUB); key(5'd9);
        run(32'hFFFF_FFFC, 1);
        key(K_MUL); check("chain_a", bus.disp_val, 32'hFFFF_FFFC);
        key(5'd1); key(5'd0);
        run(32'hFFFF_FFD8, 1);

        key(K_CLR);
        check("clr_result", bus.result, 32'd0);
        check("clr_state", 32'(bus.state_o), 32'd0);
        key(K_ADD); check("op_cnt0_ign", 32'(bus.state_o), 32'd0);
        key(K_ENT); check("ent_idle_ign", 32'(bus.state_o), 32'd0);
        for (int i = 0; i < 5; i++) key(5'd9);
        check("digit_cap", bus.disp_val, 32'd9999);
        key(K_MUL); key(5'd9); key(5'd9);
        key(K_ADD); check("op_entb_ign", 32'(bus.state_o), 32'd2);
        key(5'd9); key(5'd9);
        run(32'd99980001, 1);

        key(K_CLR);
        key(5'd6); key(K_ADD); key(K_SUB);
        check("op_replace_st", 32'(bus.state_o), 32'd1);
        check("op_replace_disp", bus.disp_val, 32'd6);
        key(5'd2);
        run(32'd4, 1);

        key(K_CLR);
        key(5'd8); key(5'h1F);
        check("unknown_ign", bus.disp_val, 32'd8);
`ifdef CALC_DIV_EN
        key(5'd0); key(5'd0); key(K_DIV); key(5'd7);   // 800/7
        run(32'd114, 33);
        key(5'd5); key(K_SUB); key(5'd9);
        run(32'hFFFF_FFFC, 1);
        key(K_DIV); key(5'd3);
        run(32'hFFFF_FFFF, 33);

        key(5'd7); key(K_DIV); key(5'd0); key(K_ENT);
        wait_state(3'd5, "err_state");
        check("err_flag", 32'(bus.err), 32'd1);
        check("err_disp", bus.disp_val, 32'd0);
        check("err_result_held", bus.result, 32'hFFFF_FFFF);
        key(5'd5);
        check("err_dig_ign", 32'(bus.state_o), 32'd5);
        key(K_CLR);
        check("errclr_state", 32'(bus.state_o), 32'd0);
        check("errclr_err", 32'(bus.err), 32'd0);
        check("errclr_result", bus.result, 32'd0);
        check("errclr_disp", bus.disp_val, 32'd0);

        key(5'd1); key(5'd0); key(K_DIV); key(5'd3); key(K_ENT);
        check("div_busy", 32'(bus.key_ready), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_state", 32'(bus.state_o), 32'd0);
        check("abort_ready", 32'(bus.key_ready), 32'd1);
        check("abort_result", bus.result, 32'd0);
        check("abort_disp", bus.disp_val, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle", 32'(bus.state_o), 32'd0);
`else
        key(K_DIV);
        check("nodiv_state", 32'(bus.state_o), 32'd0);
        check("nodiv_disp", bus.disp_val, 32'd8);
        check("nodiv_err", 32'(bus.err), 32'd0);
`endif
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
